// File: rtl/bridge_pkg.sv
// bridge_pkg: shared types and constants for the AHB-to-APB bridge.
// Holds FSM states, HTRANS codes, the APB address map and the decoder.
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_READ,
        ST_WRITE,
        ST_WRITEP,
        ST_RENABLE,
        ST_WENABLE,
        ST_WENABLEP
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [31:0] APB_BASE0 = 32'h8000_0000;
    localparam logic [31:0] APB_BASE1 = 32'h8400_0000;
    localparam logic [31:0] APB_BASE2 = 32'h8800_0000;
    localparam logic [31:0] APB_LIMIT = 32'h8C00_0000;

    localparam logic [1:0] OKAY = 2'b00;

    function automatic logic apb_hit(input logic [31:0] a);
        return (a >= APB_BASE0) && (a < APB_LIMIT);
    endfunction

    // One-hot select; bit 3 is reserved and never set.
    function automatic logic [3:0] apb_decode(input logic [31:0] a);
        if (a >= APB_BASE0 && a < APB_BASE1) return 4'b0001;
        if (a >= APB_BASE1 && a < APB_BASE2) return 4'b0010;
        if (a >= APB_BASE2 && a < APB_LIMIT) return 4'b0100;
        return 4'b0000;
    endfunction

endpackage

// File: rtl/modport_bridge_ahb_slave_if.sv
// ahb_slave_if: AHB side of the bridge.
// Address/data pipeline, transfer qualification and peripheral decode.
module ahb_slave_if
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 4
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              Hwrite,
    input  logic              Hreadyin,
    input  logic [1:0]        Htrans,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    output logic              valid,
    output logic [ADDR_W-1:0] Haddr1,
    output logic [ADDR_W-1:0] Haddr2,
    output logic [DATA_W-1:0] Hwdata1,
    output logic              Hwrite_r,
    output logic [NSLV-1:0]   sel_cur,
    output logic [NSLV-1:0]   sel_a1,
    output logic [NSLV-1:0]   sel_a2
);

    // Pipeline registers advance every cycle, stalled or not.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Haddr1   <= '0;
            Haddr2   <= '0;
            Hwdata1  <= '0;
            Hwrite_r <= 1'b0;
        end else begin
            Haddr1   <= Haddr;
            Haddr2   <= Haddr1;
            Hwdata1  <= Hwdata;
            Hwrite_r <= Hwrite;
        end
    end

    // Accept only active transfers that land in the APB window.
    always_comb begin
        valid = Hreadyin
              && (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ)
              && apb_hit(32'(Haddr));
    end

    // Decode every address the FSM may launch an APB access from.
    always_comb begin
        sel_cur = NSLV'(apb_decode(32'(Haddr)));
        sel_a1  = NSLV'(apb_decode(32'(Haddr1)));
        sel_a2  = NSLV'(apb_decode(32'(Haddr2)));
    end

endmodule

// File: rtl/modport_bridge.sv
// modport_bridge: AHB-to-APB bridge top.
// APB SETUP/ENABLE sequencer with outputs registered from next state.
module modport_bridge
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 4
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              Hwrite,
    input  logic              Hreadyin,
    input  logic [1:0]        Htrans,
    input  logic [2:0]        Hsize,
    input  logic [2:0]        Hburst,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Prdata,
    output logic              Hreadyout,
    output logic [1:0]        Hresp,
    output logic [DATA_W-1:0] Hrdata,
    output logic              Penable,
    output logic              Pwrite,
    output logic [NSLV-1:0]   Pselx,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata
);

    state_t state;
    state_t next_state;

    logic              valid;
    logic [ADDR_W-1:0] Haddr1;
    logic [ADDR_W-1:0] Haddr2;
    logic [DATA_W-1:0] Hwdata1;
    logic              Hwrite_r;
    logic [NSLV-1:0]   sel_cur;
    logic [NSLV-1:0]   sel_a1;
    logic [NSLV-1:0]   sel_a2;

    logic              nxt_penable;
    logic              nxt_pwrite;
    logic [NSLV-1:0]   nxt_pselx;
    logic [ADDR_W-1:0] nxt_paddr;
    logic [DATA_W-1:0] nxt_pwdata;
    logic              nxt_hready;
    logic              from_wep;

    logic unused_ok;
    assign unused_ok = ^{Hsize, Hburst};

    assign Hresp  = OKAY;
    assign Hrdata = Prdata;

    ahb_slave_if #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NSLV   (NSLV)
    ) u_ahb (
        .Hclk     (Hclk),
        .Hresetn  (Hresetn),
        .Hwrite   (Hwrite),
        .Hreadyin (Hreadyin),
        .Htrans   (Htrans),
        .Haddr    (Haddr),
        .Hwdata   (Hwdata),
        .valid    (valid),
        .Haddr1   (Haddr1),
        .Haddr2   (Haddr2),
        .Hwdata1  (Hwdata1),
        .Hwrite_r (Hwrite_r),
        .sel_cur  (sel_cur),
        .sel_a1   (sel_a1),
        .sel_a2   (sel_a2)
    );

    // State and APB/AHB output registers; reset aborts any access.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state     <= ST_IDLE;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Pselx     <= '0;
            Paddr     <= '0;
            Pwdata    <= '0;
            Hreadyout <= 1'b1;
        end else begin
            state     <= next_state;
            Penable   <= nxt_penable;
            Pwrite    <= nxt_pwrite;
            Pselx     <= nxt_pselx;
            Paddr     <= nxt_paddr;
            Pwdata    <= nxt_pwdata;
            Hreadyout <= nxt_hready;
        end
    end

    // Next-state decision.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid && Hwrite)
                    next_state = ST_WWAIT;
                else if (valid)
                    next_state = ST_READ;
                else
                    next_state = ST_IDLE;
            end
            ST_WWAIT:
                next_state = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:
                next_state = ST_RENABLE;
            ST_WRITE:
                next_state = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:
                next_state = ST_WENABLEP;
            ST_WENABLEP: begin
                if (!Hwrite_r)
                    next_state = ST_READ;
                else if (valid)
                    next_state = ST_WRITEP;
                else
                    next_state = ST_WRITE;
            end
        endcase
    end

    // Output values for the state being entered. After a pipelined
    // write the pending address/data sit one stage deeper (Haddr2).
    always_comb begin
        nxt_penable = Penable;
        nxt_pwrite  = Pwrite;
        nxt_pselx   = Pselx;
        nxt_paddr   = Paddr;
        nxt_pwdata  = Pwdata;
        nxt_hready  = Hreadyout;
        from_wep    = (state == ST_WENABLEP);
        unique case (next_state)
            ST_IDLE, ST_WWAIT: begin
                nxt_pselx   = '0;
                nxt_penable = 1'b0;
                nxt_hready  = 1'b1;
            end
            ST_READ: begin
                nxt_paddr   = from_wep ? Haddr2 : Haddr;
                nxt_pselx   = from_wep ? sel_a2 : sel_cur;
                nxt_pwrite  = 1'b0;
                nxt_penable = 1'b0;
                nxt_hready  = 1'b0;
            end
            ST_WRITE: begin
                nxt_paddr   = from_wep ? Haddr2 : Haddr1;
                nxt_pselx   = from_wep ? sel_a2 : sel_a1;
                nxt_pwdata  = from_wep ? Hwdata1 : Hwdata;
                nxt_pwrite  = 1'b1;
                nxt_penable = 1'b0;
                nxt_hready  = 1'b1;
            end
            ST_WRITEP: begin
                nxt_paddr   = from_wep ? Haddr2 : Haddr1;
                nxt_pselx   = from_wep ? sel_a2 : sel_a1;
                nxt_pwdata  = from_wep ? Hwdata1 : Hwdata;
                nxt_pwrite  = 1'b1;
                nxt_penable = 1'b0;
                nxt_hready  = 1'b0;
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                nxt_penable = 1'b1;
                nxt_hready  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_modport_bridge.sv
// tb_modport_bridge: directed bench for the AHB-to-APB bridge.
// Single-slave fabric: Hreadyin follows Hreadyout.
module tb_modport_bridge;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize;
    logic [2:0]  Hburst;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic        Penable;
    logic        Pwrite;
    logic [3:0]  Pselx;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;

    int n_asrt = 0;
    int n_fail = 0;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    always #5 Hclk = ~Hclk;

    assign Hreadyin = Hreadyout;

    modport_bridge dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Hsize     (Hsize),
        .Hburst    (Hburst),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Prdata    (Prdata),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Pselx     (Pselx),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " sel"}, 32'(Pselx), 32'h0);
        chk({tag, " en"}, 32'(Penable), 32'h0);
        chk({tag, " rdy"}, 32'(Hreadyout), 32'h1);
    endtask

    task automatic chk_setup(input string tag, input logic wr,
                             input logic [3:0] sel, input logic [31:0] a,
                             input logic rdy);
        chk({tag, " sel"}, 32'(Pselx), 32'(sel));
        chk({tag, " wr"}, 32'(Pwrite), 32'(wr));
        chk({tag, " addr"}, Paddr, a);
        chk({tag, " en"}, 32'(Penable), 32'h0);
        chk({tag, " rdy"}, 32'(Hreadyout), 32'(rdy));
    endtask

    task automatic chk_enable(input string tag, input logic [3:0] sel,
                              input logic [31:0] a);
        chk({tag, " sel"}, 32'(Pselx), 32'(sel));
        chk({tag, " addr"}, Paddr, a);
        chk({tag, " en"}, 32'(Penable), 32'h1);
        chk({tag, " rdy"}, 32'(Hreadyout), 32'h1);
    endtask

    initial begin
        Hresetn = 1'b0;
        Hwrite  = 1'b0;
        Htrans  = T_IDLE;
        Hsize   = 3'b010;
        Hburst  = 3'b000;
        Haddr   = 32'h0;
        Hwdata  = 32'h0;
        Prdata  = 32'h0;

        #12;
        chk("rst en", 32'(Penable), 32'h0);
        chk("rst wr", 32'(Pwrite), 32'h0);
        chk("rst sel", 32'(Pselx), 32'h0);
        chk("rst addr", Paddr, 32'h0);
        chk("rst wdata", Pwdata, 32'h0);
        chk("rst rdy", 32'(Hreadyout), 32'h1);
        chk("rst resp", 32'(Hresp), 32'h0);
        #5 Hresetn = 1'b1;

        // single write
        step();
        Htrans = T_NSEQ; Hwrite = 1'b1; Haddr = 32'h8000_0010;
        step();
        chk_idle("wr wwait");
        Htrans = T_IDLE; Hwdata = 32'hDEAD_BEEF;
        step();
        chk_setup("wr setup", 1'b1, 4'b0001, 32'h8000_0010, 1'b1);
        chk("wr setup data", Pwdata, 32'hDEAD_BEEF);
        step();
        chk_enable("wr enable", 4'b0001, 32'h8000_0010);
        chk("wr enable wr", 32'(Pwrite), 32'h1);
        chk("wr enable data", Pwdata, 32'hDEAD_BEEF);
        step();
        chk_idle("wr done");

        // single read
        Htrans = T_NSEQ; Hwrite = 1'b0; Haddr = 32'h8400_0004;
        Prdata = 32'h1234_5678;
        step();
        Htrans = T_IDLE;
        chk_setup("rd setup", 1'b0, 4'b0010, 32'h8400_0004, 1'b0);
        step();
        chk_enable("rd enable", 4'b0010, 32'h8400_0004);
        chk("rd enable wr", 32'(Pwrite), 32'h0);
        chk("rd hrdata", Hrdata, 32'h1234_5678);
        step();
        chk_idle("rd done");

        // INCR4 write burst
        Hburst = 3'b011;
        Htrans = T_NSEQ; Hwrite = 1'b1; Haddr = 32'h8800_0000;
        step();
        chk_idle("b wwait");
        Htrans = T_SEQ; Haddr = 32'h8800_0004; Hwdata = 32'hB000_0000;
        step();
        chk_setup("b0 setup", 1'b1, 4'b0100, 32'h8800_0000, 1'b0);
        chk("b0 data", Pwdata, 32'hB000_0000);
        Haddr = 32'h8800_0008; Hwdata = 32'hB000_0001;
        step();
        chk_enable("b0 enable", 4'b0100, 32'h8800_0000);
        step();
        chk_setup("b1 setup", 1'b1, 4'b0100, 32'h8800_0004, 1'b0);
        chk("b1 data", Pwdata, 32'hB000_0001);
        Haddr = 32'h8800_000C; Hwdata = 32'hB000_0002;
        step();
        chk_enable("b1 enable", 4'b0100, 32'h8800_0004);
        step();
        chk_setup("b2 setup", 1'b1, 4'b0100, 32'h8800_0008, 1'b0);
        chk("b2 data", Pwdata, 32'hB000_0002);
        Htrans = T_IDLE; Hwdata = 32'hB000_0003;
        step();
        chk_enable("b2 enable", 4'b0100, 32'h8800_0008);
        step();
        chk_setup("b3 setup", 1'b1, 4'b0100, 32'h8800_000C, 1'b1);
        chk("b3 data", Pwdata, 32'hB000_0003);
        step();
        chk_enable("b3 enable", 4'b0100, 32'h8800_000C);
        step();
        chk_idle("b done");
        Hburst = 3'b000;

        // ignored transfers
        Htrans = T_IDLE; Haddr = 32'h8000_0000;
        step();
        chk_idle("ign idle");
        Htrans = T_NSEQ; Haddr = 32'h9000_0000;
        step();
        chk_idle("ign oor a");
        Htrans = T_IDLE;
        step();
        chk_idle("ign oor b");
        Htrans = T_BUSY; Haddr = 32'h8000_0000;
        step();
        chk_idle("ign busy a");
        Htrans = T_IDLE;
        step();
        chk_idle("ign busy b");

        // write then read back to back
        Htrans = T_NSEQ; Hwrite = 1'b1; Haddr = 32'h8000_0100;
        step();
        Htrans = T_NSEQ; Hwrite = 1'b0; Haddr = 32'h8400_0200;
        Hwdata = 32'hCAFE_F00D;
        step();
        chk_setup("bb w setup", 1'b1, 4'b0001, 32'h8000_0100, 1'b0);
        chk("bb w data", Pwdata, 32'hCAFE_F00D);
        Htrans = T_IDLE; Prdata = 32'hA5A5_5A5A;
        step();
        chk_enable("bb w enable", 4'b0001, 32'h8000_0100);
        step();
        chk_setup("bb r setup", 1'b0, 4'b0010, 32'h8400_0200, 1'b0);
        step();
        chk_enable("bb r enable", 4'b0010, 32'h8400_0200);
        chk("bb r hrdata", Hrdata, 32'hA5A5_5A5A);
        step();
        chk_idle("bb done");

        // reset in the middle of a write
        Htrans = T_NSEQ; Hwrite = 1'b1; Haddr = 32'h8000_0020;
        step();
        Htrans = T_IDLE; Hwdata = 32'h1111_2222;
        step();
        chk_setup("mr setup", 1'b1, 4'b0001, 32'h8000_0020, 1'b1);
        #2 Hresetn = 1'b0;
        #1;
        chk("mr en", 32'(Penable), 32'h0);
        chk("mr wr", 32'(Pwrite), 32'h0);
        chk("mr sel", 32'(Pselx), 32'h0);
        chk("mr addr", Paddr, 32'h0);
        chk("mr wdata", Pwdata, 32'h0);
        chk("mr rdy", 32'(Hreadyout), 32'h1);
        chk("mr resp", 32'(Hresp), 32'h0);
        #3 Hresetn = 1'b1;
        step();
        chk_idle("mr after a");
        step();
        chk_idle("mr after b");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
